// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter, drives the synchronous-read
// instruction memory and hands {instr, pc, pc+4} to decode over a
// valid/stall handshake. A one-entry skid buffer catches the word that
// is already in flight when decode stalls, so nothing is lost or
// duplicated and the stream resumes without a bubble.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_FILL   | nothing in flight, skid empty (after reset or redirect)
// ST_STREAM | one read in flight; its data arrives on Instruction this cycle
// ST_HOLD   | decode stalled; the in-flight word is parked in the skid buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    // MEM_WORDS is a power of two, so the wrap is a simple mask.
    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4) - 32'd1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inflight_pc_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_pc4_q;
    logic        misaligned_q;
    logic [31:0] count_q;

    logic        accept;
    logic        consume;
    logic [31:0] pc_incr;
    logic [31:0] inflight_pc4;
    logic [31:0] skid_pc4;
    logic [31:0] redirect_target;

    // Handshake terms and wrapped address arithmetic.
    always_comb begin
        accept          = ~valid_q | ~stall;
        consume         = valid_q & ~stall;
        pc_incr         = (pc_q + 32'd4) & PC_MASK;
        inflight_pc4    = (inflight_pc_q + 32'd4) & PC_MASK;
        skid_pc4        = (skid_pc_q + 32'd4) & PC_MASK;
        redirect_target = {redirect_pc[31:2], 2'b00} & PC_MASK;
    end

    // Fetch control: redirect flushes first, then skid drain, then skid
    // capture on stall, otherwise stream the in-flight word to decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FILL;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'd0;
            skid_instr_q  <= 32'd0;
            skid_pc_q     <= 32'd0;
            valid_q       <= 1'b0;
            instr_q       <= 32'd0;
            out_pc_q      <= 32'd0;
            out_pc4_q     <= 32'd0;
            misaligned_q  <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            // The word on the outputs is consumed even on a redirect edge.
            if (consume) begin
                count_q <= count_q + 32'd1;
            end

            if (redirect) begin
                // Stall is ignored: in-flight and skid words are wrong-path.
                pc_q    <= redirect_target;
                state_q <= ST_FILL;
                valid_q <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    misaligned_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (accept) begin
                            valid_q       <= 1'b1;
                            instr_q       <= skid_instr_q;
                            out_pc_q      <= skid_pc_q;
                            out_pc4_q     <= skid_pc4;
                            inflight_pc_q <= pc_q;
                            pc_q          <= pc_incr;
                            state_q       <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (!accept) begin
                            // Memory data is only valid this cycle; park it.
                            skid_instr_q <= Instruction;
                            skid_pc_q    <= inflight_pc_q;
                            state_q      <= ST_HOLD;
                        end else begin
                            valid_q       <= 1'b1;
                            instr_q       <= Instruction;
                            out_pc_q      <= inflight_pc_q;
                            out_pc4_q     <= inflight_pc4;
                            inflight_pc_q <= pc_q;
                            pc_q          <= pc_incr;
                            state_q       <= ST_STREAM;
                        end
                    end
                    default: begin
                        // Nothing in flight, so the loaded word is marked invalid.
                        if (accept) begin
                            valid_q       <= 1'b0;
                            instr_q       <= Instruction;
                            out_pc_q      <= inflight_pc_q;
                            out_pc4_q     <= inflight_pc4;
                            inflight_pc_q <= pc_q;
                            pc_q          <= pc_incr;
                            state_q       <= ST_STREAM;
                        end
                    end
                endcase
            end
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        ReadAddress    = pc_q;
        fetch_valid    = valid_q;
        fetch_instr    = instr_q;
        fetch_pc       = out_pc_q;
        fetch_pc_plus4 = out_pc4_q;
        misaligned     = misaligned_q;
        fetch_count    = count_q;
    end

endmodule
